ssio_sdr_deskew: RTL and testbench



---
 rtl/ssio_sdr_deskew_pkg.sv | 21 ++
 rtl/ssio_lane_delay.sv | 40 ++++
 rtl/ssio_sdr_deskew.sv | 133 +++++++++++++
 tb/tb_ssio_sdr_deskew.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssio_sdr_deskew_pkg.sv
// ssio_sdr_deskew_pkg: constants shared by the ssio capture and deskew blocks.
// Holds the training FSM encodings and the delay/count field width helper.
package ssio_sdr_deskew_pkg;

   localparam int SSIO_LANES    = 4;
   localparam int SSIO_MAX_SKEW = 4;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_WAIT_FIRST = 3'd1,
      S_MEASURE    = 3'd2,
      S_LOCKED     = 3'd3,
      S_ERROR      = 3'd4
   } ssio_state_e;

   // Width of a field that must hold 0..max_skew.
   function automatic int skew_w(input int max_skew);
      return $clog2(max_skew + 1);
   endfunction

endpackage

// File: rtl/ssio_lane_delay.sv
// ssio_lane_delay: per-lane variable delay, MAX_SKEW+1 taps, registered mux.
// Ports: clk, rst (async high), d (lane bit), sel (tap index), q (delayed bit).
module ssio_lane_delay
   import ssio_sdr_deskew_pkg::*;
#(
   parameter int MAX_SKEW = SSIO_MAX_SKEW,
   parameter int SKEW_W   = skew_w(MAX_SKEW)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              d,
   input  logic [SKEW_W-1:0] sel,
   output logic              q
);

   logic [MAX_SKEW-1:0] sr_q;
   logic [MAX_SKEW:0]   tap;
   logic                pick;

   // tap[0] is the live input, tap[k] is the input k cycles ago.
   assign tap = {sr_q, d};

   always_comb begin
      pick = 1'b0;
      for (int k = 0; k <= MAX_SKEW; k++) begin
         if (sel == SKEW_W'(k)) pick = tap[k];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q <= '0;
         q    <= 1'b0;
      end else begin
         sr_q <= tap[MAX_SKEW-1:0];
         q    <= pick;
      end
   end

endmodule

// File: rtl/ssio_sdr_deskew.sv
// ssio_sdr_deskew: trains on a marker rising edge per lane and delays early
// lanes so all lanes leave cycle-aligned. Ports: clk, rst (async high),
// input_d/output_q (lane data), train_start (pulse), locked, train_error,
// lane_delay (lane n at [n*SKEW_W +: SKEW_W]).
module ssio_sdr_deskew
   import ssio_sdr_deskew_pkg::*;
#(
   parameter  int LANES    = SSIO_LANES,
   parameter  int MAX_SKEW = SSIO_MAX_SKEW,
   localparam int SKEW_W   = skew_w(MAX_SKEW)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LANES-1:0]        input_d,
   input  logic                    train_start,
   output logic [LANES-1:0]        output_q,
   output logic                    locked,
   output logic                    train_error,
   output logic [LANES*SKEW_W-1:0] lane_delay
);

   typedef logic [SKEW_W-1:0] skew_t;

   ssio_state_e      state_q, state_d;
   logic [LANES-1:0] prev_q;
   logic [LANES-1:0] edg;
   logic [LANES-1:0] hit;
   logic [LANES-1:0] seen_q, seen_d;
   skew_t            cnt_q, cnt_d;
   skew_t            max_arr;
   skew_t            arr_q [LANES];
   skew_t            arr_d [LANES];
   skew_t            dly_q [LANES];
   skew_t            dly_d [LANES];

   assign edg = input_d & ~prev_q;
   assign hit = edg & ~seen_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      seen_d  = seen_q;
      arr_d   = arr_q;
      dly_d   = dly_q;
      max_arr = '0;
      if (train_start) begin
         state_d = S_WAIT_FIRST;
         cnt_d   = '0;
         seen_d  = '0;
         arr_d   = '{default: '0};
         dly_d   = '{default: '0};
      end else begin
         unique case (state_q)
            S_WAIT_FIRST: begin
               if (|edg) begin
                  for (int n = 0; n < LANES; n++) begin
                     if (edg[n]) arr_d[n] = '0;
                  end
                  seen_d  = edg;
                  cnt_d   = skew_t'(1);
                  state_d = (&edg) ? S_LOCKED : S_MEASURE;
               end
            end
            S_MEASURE: begin
               for (int n = 0; n < LANES; n++) begin
                  if (hit[n]) arr_d[n] = cnt_q;
               end
               seen_d = seen_q | hit;
               if (&seen_d) begin
                  state_d = S_LOCKED;
               end else if (cnt_q == skew_t'(MAX_SKEW)) begin
                  state_d = S_ERROR;
               end else begin
                  cnt_d = cnt_q + skew_t'(1);
               end
            end
            S_IDLE, S_LOCKED, S_ERROR: ;
            default: state_d = S_IDLE;
         endcase
         // Latch delays on the edge that sees the last lane arrive.
         if (state_d == S_LOCKED && state_q != S_LOCKED) begin
            for (int n = 0; n < LANES; n++) begin
               if (arr_d[n] > max_arr) max_arr = arr_d[n];
            end
            for (int n = 0; n < LANES; n++) begin
               dly_d[n] = max_arr - arr_d[n];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         prev_q  <= '0;
         seen_q  <= '0;
         cnt_q   <= '0;
         arr_q   <= '{default: '0};
         dly_q   <= '{default: '0};
      end else begin
         state_q <= state_d;
         prev_q  <= input_d;
         seen_q  <= seen_d;
         cnt_q   <= cnt_d;
         arr_q   <= arr_d;
         dly_q   <= dly_d;
      end
   end

   assign locked      = (state_q == S_LOCKED);
   assign train_error = (state_q == S_ERROR);

   always_comb begin
      lane_delay = '0;
      for (int n = 0; n < LANES; n++) begin
         lane_delay[n*SKEW_W +: SKEW_W] = dly_q[n];
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      ssio_lane_delay #(
         .MAX_SKEW (MAX_SKEW),
         .SKEW_W   (SKEW_W)
      ) u_dly (
         .clk (clk),
         .rst (rst),
         .d   (input_d[g]),
         .sel (dly_q[g]),
         .q   (output_q[g])
      );
   end

endmodule

// File: tb/tb_ssio_sdr_deskew.sv
// tb_ssio_sdr_deskew: scenario tasks with a history-based data model.
// Expected delays come from marker offsets: delay = max_offset - offset.
module tb_ssio_sdr_deskew;

   localparam int LANES    = 4;
   localparam int MAX_SKEW = 4;
   localparam int SW       = $clog2(MAX_SKEW + 1);

   logic                clk = 1'b0;
   logic                rst;
   logic [LANES-1:0]    input_d;
   logic                train_start;
   logic [LANES-1:0]    output_q;
   logic                locked;
   logic                train_error;
   logic [LANES*SW-1:0] lane_delay;

   int checks   = 0;
   int failures = 0;

   logic [LANES-1:0] hist[$];
   int  mdly [LANES];
   int  pdly [LANES];
   bit  pend;

   ssio_sdr_deskew #(
      .LANES    (LANES),
      .MAX_SKEW (MAX_SKEW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .input_d     (input_d),
      .train_start (train_start),
      .output_q    (output_q),
      .locked      (locked),
      .train_error (train_error),
      .lane_delay  (lane_delay)
   );

   always #5 clk = ~clk;

   function automatic logic [LANES*SW-1:0] pack_dly();
      logic [LANES*SW-1:0] r;
      r = '0;
      for (int n = 0; n < LANES; n++) r[n*SW +: SW] = SW'(mdly[n]);
      return r;
   endfunction

   // One cycle: drive, predict output from history, clock, compare.
   task automatic tick(input logic [LANES-1:0] v, input logic ts);
      logic [LANES-1:0] exp;
      int i;
      input_d     = v;
      train_start = ts;
      hist.push_back(v);
      for (int n = 0; n < LANES; n++) begin
         i = hist.size() - 1 - mdly[n];
         exp[n] = (i >= 0) ? hist[i][n] : 1'b0;
      end
      if (ts) begin
         for (int n = 0; n < LANES; n++) mdly[n] = 0;
      end else if (pend) begin
         for (int n = 0; n < LANES; n++) mdly[n] = pdly[n];
      end
      pend = 0;
      @(posedge clk);
      #1;
      checks++;
      if (output_q !== exp) begin
         failures++;
         $display("FAIL data: got %b expected %b", output_q, exp);
      end
      checks++;
      if (lane_delay !== pack_dly()) begin
         failures++;
         $display("FAIL lane_delay: got %h expected %h",
                  lane_delay, pack_dly());
      end
   endtask

   task automatic run_lock(input int off[LANES], input string nm);
      logic [LANES-1:0] v;
      int mx;
      mx = 0;
      for (int n = 0; n < LANES; n++) if (off[n] > mx) mx = off[n];
      tick('0, 1'b1);
      checks++;
      if (locked !== 1'b0 || train_error !== 1'b0) begin
         failures++;
         $display("FAIL %s start: locked=%b err=%b expected 0 0",
                  nm, locked, train_error);
      end
      repeat ($urandom_range(1, 3)) tick('0, 1'b0);
      for (int k = 0; k <= mx; k++) begin
         for (int n = 0; n < LANES; n++) v[n] = (off[n] <= k);
         if (k == mx) begin
            for (int n = 0; n < LANES; n++) pdly[n] = mx - off[n];
            pend = 1;
         end
         tick(v, 1'b0);
         checks++;
         if (locked !== (k == mx)) begin
            failures++;
            $display("FAIL %s lock k=%0d: got %b expected %b",
                     nm, k, locked, (k == mx));
         end
      end
      checks++;
      if (train_error !== 1'b0) begin
         failures++;
         $display("FAIL %s err: got %b expected 0", nm, train_error);
      end
      repeat (20) tick(LANES'($urandom), 1'b0);
      checks++;
      if (locked !== 1'b1) begin
         failures++;
         $display("FAIL %s hold: got %b expected 1", nm, locked);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({output_q, locked, train_error, lane_delay} !== '0) begin
         failures++;
         $display("FAIL reset: got q=%b l=%b e=%b d=%h expected 0",
                  output_q, locked, train_error, lane_delay);
      end
      rst = 1'b0;
      repeat (8) tick(LANES'($urandom), 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL idle_edges: got locked=%b expected 0", locked);
      end
   endtask

   task automatic test_aligned();
      run_lock('{0, 0, 0, 0}, "aligned");
   endtask

   task automatic test_skewed();
      run_lock('{0, 2, 1, 3}, "skewed");
      checks++;
      if (lane_delay !== 12'h08B) begin
         failures++;
         $display("FAIL skew_delay: got %h expected 08b", lane_delay);
      end
   endtask

   task automatic test_retrain();
      tick('0, 1'b0);
      tick('0, 1'b0);
      tick(4'b0001, 1'b1);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL retrain_drop: got %b expected 0", locked);
      end
      tick(4'b1110, 1'b0);
      checks++;
      if (locked !== 1'b0) begin
         failures++;
         $display("FAIL retrain_mid: got %b expected 0", locked);
      end
      pdly = '{0, 1, 1, 1};
      pend = 1;
      tick(4'b1111, 1'b0);
      checks++;
      if (locked !== 1'b1 || lane_delay !== 12'h248) begin
         failures++;
         $display("FAIL retrain_lock: got l=%b d=%h expected 1 248",
                  locked, lane_delay);
      end
      repeat (10) tick(LANES'($urandom), 1'b0);
   endtask

   task automatic test_over_skew();
      tick('0, 1'b1);
      tick('0, 1'b0);
      tick(4'b0111, 1'b0);
      for (int k = 1; k <= 5; k++) begin
         tick((k < 5) ? 4'b0111 : 4'b1111, 1'b0);
         checks++;
         if (train_error !== (k >= 4) || locked !== 1'b0) begin
            failures++;
            $display("FAIL overskew k=%0d: got e=%b l=%b expected %b 0",
                     k, train_error, locked, (k >= 4));
         end
      end
      checks++;
      if (lane_delay !== '0) begin
         failures++;
         $display("FAIL overskew_delay: got %h expected 0", lane_delay);
      end
   endtask

   task automatic test_boundary();
      run_lock('{0, 0, 4, 0}, "boundary");
      checks++;
      if (lane_delay !== 12'h824) begin
         failures++;
         $display("FAIL boundary_delay: got %h expected 824", lane_delay);
      end
   endtask

   task automatic test_reset_mid();
      tick('0, 1'b1);
      tick('0, 1'b0);
      tick(4'b0011, 1'b0);
      tick(4'b0011, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({output_q, locked, train_error, lane_delay} !== '0) begin
         failures++;
         $display("FAIL reset_mid: got q=%b l=%b e=%b d=%h expected 0",
                  output_q, locked, train_error, lane_delay);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      hist.delete();
      for (int n = 0; n < LANES; n++) mdly[n] = 0;
      tick(4'b1111, 1'b0);
      tick(4'b0000, 1'b0);
      tick(4'b1111, 1'b0);
      tick(4'b1111, 1'b0);
      checks++;
      if (locked !== 1'b0 || train_error !== 1'b0) begin
         failures++;
         $display("FAIL reset_norestart: got l=%b e=%b expected 0 0",
                  locked, train_error);
      end
   endtask

   task automatic test_back_to_back();
      int off[LANES];
      int mn;
      for (int it = 0; it < 6; it++) begin
         mn = MAX_SKEW;
         for (int n = 0; n < LANES; n++) begin
            off[n] = $urandom_range(0, MAX_SKEW);
            if (off[n] < mn) mn = off[n];
         end
         for (int n = 0; n < LANES; n++) off[n] -= mn;
         run_lock(off, "random");
      end
   endtask

   initial begin
      rst         = 1'b1;
      input_d     = '0;
      train_start = 1'b0;
      pend        = 0;
      for (int n = 0; n < LANES; n++) mdly[n] = 0;
      test_reset();
      test_aligned();
      test_skewed();
      test_retrain();
      test_over_skew();
      test_boundary();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
